// File: rtl/npc_btb_pkg.sv
// Shared types, constants and PC slicing helpers for the associative BTB.
package npc_btb_pkg;

  localparam int IDX_W    = 6;
  localparam int WAYS     = 2;
  localparam int TAG_W    = 8;
  localparam int ADDR_W   = 32;
  localparam int SETS     = 1 << IDX_W;
  localparam int CTR_W    = 2;
  localparam logic [CTR_W-1:0] CTR_INIT = 2'b10;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } btb_entry_t;

  // Two-bit saturating direction counter step.
  function automatic logic [CTR_W-1:0] sat_ctr(input logic [CTR_W-1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction

endpackage

// File: rtl/npc_btb_way.sv
// One BTB way: SETS entries, single write port, two combinational read ports
// (lookup side and update side). Only the valid bits are reset.
module npc_btb_way
  import npc_btb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry,
  input  logic [IDX_W-1:0] rd_idx_a,
  output btb_entry_t       rd_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_b
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q    [SETS];
  logic [ADDR_W-1:0] target_q [SETS];
  logic [CTR_W-1:0]  ctr_q    [SETS];

  // Valid bits: cleared asynchronously, written by the shared write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid_q <= '0;
    else if (we) valid_q[wr_idx] <= wr_entry.valid;
  end

  // Payload storage: no reset, contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
      ctr_q[wr_idx]    <= wr_entry.ctr;
    end
  end

  // Combinational reads; a write in the same cycle is not yet visible.
  always_comb begin
    rd_a.valid  = valid_q[rd_idx_a];
    rd_a.tag    = tag_q[rd_idx_a];
    rd_a.target = target_q[rd_idx_a];
    rd_a.ctr    = ctr_q[rd_idx_a];
    rd_b.valid  = valid_q[rd_idx_b];
    rd_b.tag    = tag_q[rd_idx_b];
    rd_b.target = target_q[rd_idx_b];
    rd_b.ctr    = ctr_q[rd_idx_b];
  end

endmodule

// File: rtl/npc_btb_assoc.sv
// Set-associative branch target buffer: clear/run FSM, lookup pipeline with
// registered response, counter update and round-robin allocation per set.
module npc_btb_assoc
  import npc_btb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_ready,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_taken,
  output logic [ADDR_W-1:0] rsp_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              upd_ready
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;
  logic [WAY_W-1:0] rr_q [SETS];

  btb_entry_t       lk_rd [WAYS];
  btb_entry_t       up_rd [WAYS];
  btb_entry_t       wr_entry, lk_sel;
  logic [IDX_W-1:0] wr_idx;
  logic [WAYS-1:0]  way_we;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_fire, upd_fire, lk_hit, up_hit, has_free, rr_inc;
  logic [WAY_W-1:0] up_way, free_way, alloc_way;

  assign lk_idx    = idx_of(lk_pc);
  assign lk_tag    = tag_of(lk_pc);
  assign up_idx    = idx_of(upd_pc);
  assign up_tag    = tag_of(upd_pc);
  assign lk_ready  = (state_q == ST_RUN);
  assign upd_ready = (state_q == ST_RUN);
  // A flush cancels any lookup or update presented in the same cycle.
  assign lk_fire   = lk_valid && lk_ready && !flush;
  assign upd_fire  = upd_valid && upd_ready && !flush;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    npc_btb_way u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (way_we[g]),
      .wr_idx   (wr_idx),
      .wr_entry (wr_entry),
      .rd_idx_a (lk_idx),
      .rd_a     (lk_rd[g]),
      .rd_idx_b (up_idx),
      .rd_b     (up_rd[g])
    );
  end

  // FSM state and sweep index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Next state: sweep every set once, restart on flush, then run.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (flush) begin
      state_d = ST_CLEAR;
      clr_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
    end
  end

  // Lookup-side match: scan high to low so the lowest matching way wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_sel = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_rd[w].valid && lk_rd[w].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_sel = lk_rd[w];
      end
    end
  end

  // Update-side match and lowest free way in the update set.
  always_comb begin
    up_hit   = 1'b0;
    up_way   = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (up_rd[w].valid && up_rd[w].tag == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!up_rd[w].valid) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    alloc_way = has_free ? free_way : rr_q[up_idx];
  end

  // Write port steering: sweep clears all ways, otherwise counter update or allocation.
  always_comb begin
    way_we   = '0;
    wr_idx   = up_idx;
    wr_entry = '0;
    rr_inc   = 1'b0;
    if (state_q == ST_CLEAR) begin
      way_we = '1;
      wr_idx = clr_q;
    end else if (upd_fire) begin
      if (up_hit) begin
        way_we[up_way] = 1'b1;
        wr_entry       = up_rd[up_way];
        wr_entry.ctr   = sat_ctr(up_rd[up_way].ctr, upd_taken);
        if (upd_taken) wr_entry.target = upd_target;
      end else if (upd_taken) begin
        way_we[alloc_way] = 1'b1;
        wr_entry.valid    = 1'b1;
        wr_entry.tag      = up_tag;
        wr_entry.target   = upd_target;
        wr_entry.ctr      = CTR_INIT;
        rr_inc            = !has_free;
      end
    end
  end

  // Round-robin victim pointers, one per set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (flush && state_q == ST_RUN) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rr_inc) begin
      rr_q[up_idx] <= (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;
    end
  end

  // Registered prediction for the lookup accepted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_target <= '0;
    end else begin
      rsp_valid  <= lk_fire;
      rsp_hit    <= lk_fire && lk_hit;
      rsp_taken  <= lk_fire && lk_hit && lk_sel.ctr[CTR_W-1];
      rsp_target <= (lk_fire && lk_hit) ? lk_sel.target : '0;
    end
  end

endmodule
